// File: rtl/spi_slave_regfile.sv
// SPI mode-0 slave that decodes 40-bit {rw, addr[6:0], data[31:0]} frames into a
// local register file and serves read frames back on MISO. All SPI pins are oversampled on clk.
module spi_slave_regfile #(
    parameter int NUM_REGS    = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        spi_sclk,
    input  logic        spi_cs_n,
    input  logic        spi_mosi,
    output logic        spi_miso,
    output logic        spi_miso_oe,
    output logic        wr_strobe,
    output logic [6:0]  wr_addr,
    output logic [31:0] wr_data,
    output logic        frame_err,
    output logic        addr_err,
    output logic [15:0] frame_count,
    input  logic [6:0]  loc_rd_addr,
    output logic [31:0] loc_rd_data
);

    localparam int IDX_W = $clog2(NUM_REGS);

    typedef enum logic [2:0] {IDLE_WAIT, IDLE, HEADER, DATA, DONE} state_t;

    state_t                 r_state, w_nextState;
    logic [SYNC_STAGES-1:0] r_sclkSync, r_csSync, r_mosiSync;
    logic                   r_sclkPrev;
    logic [5:0]             r_bitCnt;
    logic [30:0]            r_shiftIn;
    logic [31:0]            r_shiftOut;
    logic                   r_rw;
    logic [6:0]             r_addr;
    logic [31:0]            r_regs [NUM_REGS];

    logic        w_sclk, w_cs, w_mosi, w_sclkRise, w_sclkFall;
    logic        w_hdrDone, w_frameDone, w_abort, w_doWrite;
    logic [6:0]  w_hdrAddr;
    logic        w_hdrRw;
    logic [31:0] w_data;

    function automatic logic addrOk(input logic [6:0] a);
        return ({1'b0, a} < 8'(NUM_REGS));
    endfunction

    assign w_sclk      = r_sclkSync[SYNC_STAGES-1];
    assign w_cs        = r_csSync[SYNC_STAGES-1];
    assign w_mosi      = r_mosiSync[SYNC_STAGES-1];
    assign w_sclkRise  = w_sclk & ~r_sclkPrev;
    assign w_sclkFall  = ~w_sclk & r_sclkPrev;
    assign w_hdrRw     = r_shiftIn[6];
    assign w_hdrAddr   = {r_shiftIn[5:0], w_mosi};
    assign w_data      = {r_shiftIn, w_mosi};
    assign w_doWrite   = w_frameDone & ~r_rw & addrOk(r_addr);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sclkSync <= '0;
            r_csSync   <= '0;
            r_mosiSync <= '0;
            r_sclkPrev <= 1'b0;
            r_state    <= IDLE_WAIT;
        end else begin
            r_sclkSync <= {r_sclkSync[SYNC_STAGES-2:0], spi_sclk};
            r_csSync   <= {r_csSync[SYNC_STAGES-2:0], spi_cs_n};
            r_mosiSync <= {r_mosiSync[SYNC_STAGES-2:0], spi_mosi};
            r_sclkPrev <= w_sclk;
            r_state    <= w_nextState;
        end
    end

    // IDLE is only ever entered with cs_n high, so a low level there marks the frame start.
    always_comb begin
        w_nextState = r_state;
        w_hdrDone   = 1'b0;
        w_frameDone = 1'b0;
        w_abort     = 1'b0;
        case (r_state)
            IDLE_WAIT: if (w_cs) w_nextState = IDLE;
            IDLE:      if (!w_cs) w_nextState = HEADER;
            HEADER: begin
                if (w_cs) begin
                    w_abort     = 1'b1;
                    w_nextState = IDLE;
                end else if (w_sclkRise && r_bitCnt == 6'd7) begin
                    w_hdrDone   = 1'b1;
                    w_nextState = DATA;
                end
            end
            DATA: begin
                if (w_cs) begin
                    w_abort     = 1'b1;
                    w_nextState = IDLE;
                end else if (w_sclkRise && r_bitCnt == 6'd39) begin
                    w_frameDone = 1'b1;
                    w_nextState = DONE;
                end
            end
            DONE:      if (w_cs) w_nextState = IDLE;
            default:   w_nextState = IDLE_WAIT;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_bitCnt    <= '0;
            r_shiftIn   <= '0;
            r_shiftOut  <= '0;
            r_rw        <= 1'b0;
            r_addr      <= '0;
            wr_strobe   <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
            frame_err   <= 1'b0;
            addr_err    <= 1'b0;
            frame_count <= '0;
            spi_miso    <= 1'b0;
            spi_miso_oe <= 1'b0;
        end else begin
            wr_strobe <= 1'b0;
            addr_err  <= 1'b0;
            frame_err <= w_abort;
            if (r_state == IDLE) begin
                r_bitCnt <= '0;
            end else if ((r_state == HEADER || r_state == DATA) && w_sclkRise && !w_cs
                         && r_bitCnt != 6'd40) begin
                r_shiftIn <= {r_shiftIn[29:0], w_mosi};
                r_bitCnt  <= r_bitCnt + 6'd1;
            end
            if (w_hdrDone) begin
                r_rw       <= w_hdrRw;
                r_addr     <= w_hdrAddr;
                addr_err   <= ~addrOk(w_hdrAddr);
                r_shiftOut <= (w_hdrRw && addrOk(w_hdrAddr)) ? r_regs[w_hdrAddr[IDX_W-1:0]] : '0;
            end
            if (w_frameDone) frame_count <= frame_count + 16'd1;
            if (w_doWrite) begin
                wr_strobe <= 1'b1;
                wr_addr   <= r_addr;
                wr_data   <= w_data;
            end
            // First falling edge after the header presents bit31; each later one advances a bit.
            if (w_frameDone || w_abort || r_state != DATA) begin
                spi_miso    <= 1'b0;
                spi_miso_oe <= 1'b0;
            end else if (w_sclkFall && r_rw) begin
                spi_miso    <= r_shiftOut[31];
                spi_miso_oe <= 1'b1;
                r_shiftOut  <= {r_shiftOut[30:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
            loc_rd_data <= '0;
        end else begin
            if (w_doWrite) r_regs[r_addr[IDX_W-1:0]] <= w_data;
            loc_rd_data <= addrOk(loc_rd_addr) ? r_regs[loc_rd_addr[IDX_W-1:0]] : '0;
        end
    end

endmodule

// File: tb/tb_spi_slave_regfile.sv
// Directed bench for spi_slave_regfile: a table of 40-bit frames with hand-computed
// results, plus a hand-written reset-in-the-middle-of-a-frame sequence.
module tb_spi_slave_regfile;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        spi_sclk = 1'b0;
    logic        spi_cs_n = 1'b1;
    logic        spi_mosi = 1'b0;
    logic        spi_miso, spi_miso_oe, wr_strobe, frame_err, addr_err;
    logic [6:0]  wr_addr;
    logic [31:0] wr_data;
    logic [15:0] frame_count;
    logic [6:0]  loc_rd_addr = '0;
    logic [31:0] loc_rd_data;

    spi_slave_regfile dut (
        .clk(clk), .reset(reset), .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n),
        .spi_mosi(spi_mosi), .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
        .wr_strobe(wr_strobe), .wr_addr(wr_addr), .wr_data(wr_data),
        .frame_err(frame_err), .addr_err(addr_err), .frame_count(frame_count),
        .loc_rd_addr(loc_rd_addr), .loc_rd_data(loc_rd_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [39:0] frame;
        int          nbits;
        int          expWr;
        logic [6:0]  expWrAddr;
        logic [31:0] expWrData;
        logic [31:0] expOld;
        int          expAddrErr;
        int          expFrameErr;
        logic [15:0] expCount;
        logic [6:0]  rdAddr;
        logic [31:0] expRd;
        logic [31:0] expMiso;
        int          expOe;
    } vec_t;

    int checks = 0;
    int failures = 0;

    int          wrTotal = 0, addrErrTotal = 0, frameErrTotal = 0;
    logic [6:0]  lastAddr = '0;
    logic [31:0] lastData = '0, rdAtStrobe = '0;

    always @(negedge clk) begin
        if (wr_strobe) begin
            wrTotal++;
            lastAddr   = wr_addr;
            lastData   = wr_data;
            rdAtStrobe = loc_rd_data;
        end
        if (addr_err)  addrErrTotal++;
        if (frame_err) frameErrTotal++;
    end

    logic [31:0] misoWord;
    int          oeRises;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    // One sclk cycle per bit: 4 clk low then 4 clk high; MISO/OE observed at each rise.
    task automatic shiftBits(input logic [39:0] frame, input int first, input int last);
        for (int i = first; i <= last; i++) begin
            spi_mosi = (i < 40) ? frame[39-i] : 1'b1;
            #40;
            spi_sclk = 1'b1;
            if (i >= 8 && i < 40) misoWord[39-i] = spi_miso;
            if (spi_miso_oe) oeRises++;
            #40;
            spi_sclk = 1'b0;
        end
    endtask

    task automatic applyStimulus(input logic [39:0] frame, input int nbits);
        misoWord = '0;
        oeRises  = 0;
        spi_cs_n = 1'b0;
        #80;
        shiftBits(frame, 0, nbits - 1);
        #80;
        spi_cs_n = 1'b1;
        #160;
    endtask

    vec_t vecs [8];

    initial begin
        int wr0, ae0, fe0;

        vecs[0] = '{40'h03_DEADBEEF, 40, 1, 7'h03, 32'hDEADBEEF, 32'h0, 0, 0, 16'd1, 7'h03, 32'hDEADBEEF, 32'h0, 0};
        vecs[1] = '{40'h83_00000000, 40, 0, 7'h00, 32'h0, 32'h0, 0, 0, 16'd2, 7'h03, 32'hDEADBEEF, 32'hDEADBEEF, 32};
        vecs[2] = '{40'h20_CAFEF00D, 40, 0, 7'h00, 32'h0, 32'h0, 1, 0, 16'd3, 7'h20, 32'h0, 32'h0, 0};
        vecs[3] = '{40'h05_11111111, 20, 0, 7'h00, 32'h0, 32'h0, 0, 1, 16'd3, 7'h05, 32'h0, 32'h0, 0};
        vecs[4] = '{40'h05_A5A5A5A5, 40, 1, 7'h05, 32'hA5A5A5A5, 32'h0, 0, 0, 16'd4, 7'h05, 32'hA5A5A5A5, 32'h0, 0};
        vecs[5] = '{40'h01_12345678, 45, 1, 7'h01, 32'h12345678, 32'h0, 0, 0, 16'd5, 7'h01, 32'h12345678, 32'h0, 0};
        vecs[6] = '{40'h80_00000000, 40, 0, 7'h00, 32'h0, 32'h0, 0, 0, 16'd6, 7'h00, 32'h0, 32'h0, 32};
        vecs[7] = '{40'hA0_00000000, 40, 0, 7'h00, 32'h0, 32'h0, 1, 0, 16'd7, 7'h03, 32'hDEADBEEF, 32'h0, 32};

        #20;
        checkOutput("reset_frame_count", 32'(frame_count), 32'h0);
        checkOutput("reset_rd_data", loc_rd_data, 32'h0);
        checkOutput("reset_outputs", {27'h0, spi_miso, spi_miso_oe, wr_strobe, frame_err, addr_err}, 32'h0);
        #20;
        reset = 1'b0;
        #100;

        for (int v = 0; v < 8; v++) begin
            loc_rd_addr = vecs[v].rdAddr;
            wr0 = wrTotal; ae0 = addrErrTotal; fe0 = frameErrTotal;
            applyStimulus(vecs[v].frame, vecs[v].nbits);
            $display("[TB] vector %0d frame=0x%010h bits=%0d", v, vecs[v].frame, vecs[v].nbits);
            checkOutput("wr_strobe_count", 32'(wrTotal - wr0), 32'(vecs[v].expWr));
            checkOutput("addr_err_count", 32'(addrErrTotal - ae0), 32'(vecs[v].expAddrErr));
            checkOutput("frame_err_count", 32'(frameErrTotal - fe0), 32'(vecs[v].expFrameErr));
            checkOutput("frame_count", 32'(frame_count), 32'(vecs[v].expCount));
            checkOutput("oe_rises", 32'(oeRises), 32'(vecs[v].expOe));
            checkOutput("miso_word", misoWord, vecs[v].expMiso);
            checkOutput("loc_rd_data", loc_rd_data, vecs[v].expRd);
            checkOutput("oe_idle", {31'h0, spi_miso_oe}, 32'h0);
            if (vecs[v].expWr != 0) begin
                checkOutput("wr_addr", 32'(lastAddr), 32'(vecs[v].expWrAddr));
                checkOutput("wr_data", lastData, vecs[v].expWrData);
                checkOutput("rd_same_cycle_old", rdAtStrobe, vecs[v].expOld);
            end
        end

        // Reset lands mid-DATA while cs_n stays low; the rest of that frame must be ignored.
        loc_rd_addr = 7'h07;
        wr0 = wrTotal; fe0 = frameErrTotal;
        spi_cs_n = 1'b0;
        #80;
        shiftBits(40'h07_0BADF00D, 0, 19);
        reset = 1'b1;
        #30;
        reset = 1'b0;
        shiftBits(40'h07_0BADF00D, 20, 39);
        #80;
        spi_cs_n = 1'b1;
        #160;
        checkOutput("rst_mid_wr_count", 32'(wrTotal - wr0), 32'h0);
        checkOutput("rst_mid_frame_err", 32'(frameErrTotal - fe0), 32'h0);
        checkOutput("rst_mid_frame_count", 32'(frame_count), 32'h0);
        checkOutput("rst_mid_reg7", loc_rd_data, 32'h0);
        loc_rd_addr = 7'h03;
        #20;
        checkOutput("rst_cleared_reg3", loc_rd_data, 32'h0);

        loc_rd_addr = 7'h07;
        wr0 = wrTotal;
        applyStimulus(40'h07_0BADF00D, 40);
        checkOutput("post_rst_wr_count", 32'(wrTotal - wr0), 32'h1);
        checkOutput("post_rst_wr_data", lastData, 32'h0BADF00D);
        checkOutput("post_rst_frame_count", 32'(frame_count), 32'h1);
        checkOutput("post_rst_reg7", loc_rd_data, 32'h0BADF00D);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
